// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/response bundle between the IFU, LSU, memory port and the arbiter
//
// Purpose: groups every handshake/bus signal of mem_port_arbiter so the block
// takes a single interface port. Signal names are written from the arbiter's
// point of view (i_* driven into the arbiter, o_* driven by it).
//   slave  modport : used by the arbiter
//   master modport : used by whatever drives the IFU, LSU and memory sides
// Signal groups:
//   IFU request/response : i_ifu_req_valid, o_ifu_req_ready, i_ifu_addr,
//                          o_ifu_rsp_valid, i_ifu_rsp_ready, o_ifu_rdata, o_ifu_rsp_err
//   LSU request/response : i_lsu_req_valid, o_lsu_req_ready, i_lsu_addr, i_lsu_wdata,
//                          i_lsu_wen, i_lsu_memop, o_lsu_rsp_valid, i_lsu_rsp_ready,
//                          o_lsu_rdata, o_lsu_rsp_err
//   memory port          : o_mem_req_valid, i_mem_req_ready, o_mem_addr, o_mem_wdata,
//                          o_mem_wen, o_mem_memop, i_mem_rsp_valid, o_mem_rsp_ready,
//                          i_mem_rdata, i_mem_rsp_err
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_ifu_req_valid;
   logic          o_ifu_req_ready;
   logic [AW-1:0] i_ifu_addr;
   logic          o_ifu_rsp_valid;
   logic          i_ifu_rsp_ready;
   logic [DW-1:0] o_ifu_rdata;
   logic          o_ifu_rsp_err;

   logic          i_lsu_req_valid;
   logic          o_lsu_req_ready;
   logic [AW-1:0] i_lsu_addr;
   logic [DW-1:0] i_lsu_wdata;
   logic          i_lsu_wen;
   logic [2:0]    i_lsu_memop;
   logic          o_lsu_rsp_valid;
   logic          i_lsu_rsp_ready;
   logic [DW-1:0] o_lsu_rdata;
   logic          o_lsu_rsp_err;

   logic          o_mem_req_valid;
   logic          i_mem_req_ready;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic          o_mem_wen;
   logic [2:0]    o_mem_memop;
   logic          i_mem_rsp_valid;
   logic          o_mem_rsp_ready;
   logic [DW-1:0] i_mem_rdata;
   logic          i_mem_rsp_err;

   modport slave (
      input  i_ifu_req_valid, i_ifu_addr, i_ifu_rsp_ready,
      output o_ifu_req_ready, o_ifu_rsp_valid, o_ifu_rdata, o_ifu_rsp_err,
      input  i_lsu_req_valid, i_lsu_addr, i_lsu_wdata, i_lsu_wen, i_lsu_memop, i_lsu_rsp_ready,
      output o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rdata, o_lsu_rsp_err,
      input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rdata, i_mem_rsp_err,
      output o_mem_req_valid, o_mem_addr, o_mem_wdata, o_mem_wen, o_mem_memop, o_mem_rsp_ready
   );

   modport master (
      output i_ifu_req_valid, i_ifu_addr, i_ifu_rsp_ready,
      input  o_ifu_req_ready, o_ifu_rsp_valid, o_ifu_rdata, o_ifu_rsp_err,
      output i_lsu_req_valid, i_lsu_addr, i_lsu_wdata, i_lsu_wen, i_lsu_memop, i_lsu_rsp_ready,
      input  o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rdata, o_lsu_rsp_err,
      output i_mem_req_ready, i_mem_rsp_valid, i_mem_rdata, i_mem_rsp_err,
      input  o_mem_req_valid, o_mem_addr, o_mem_wdata, o_mem_wen, o_mem_memop, o_mem_rsp_ready
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IFU/LSU arbiter for a single memory port with response timeout
//
// Purpose: grants the memory port to one requester at a time (round-robin on
// ties), keeps exactly one transaction outstanding, routes the response to the
// issuing master and converts a hung slave into an error response.
// Ports:
//   i_clk   : core clock
//   i_rst_n : asynchronous active-low reset
//   bus     : mem_port_arbiter_if.slave, all IFU/LSU/memory handshake signals
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int TW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [TW-1:0] T_MAX  = '1;
   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_grant_q, last_grant_d;
   logic          stale_q, stale_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          wen_q, wen_d;
   logic [2:0]    memop_q, memop_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          ifu_ready, lsu_ready, grant_lsu;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IFU;
         last_grant_q <= OWN_LSU;
         stale_q      <= 1'b0;
         timer_q      <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wen_q        <= 1'b0;
         memop_q      <= 3'b000;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         stale_q      <= stale_d;
         timer_q      <= timer_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wen_q        <= wen_d;
         memop_q      <= memop_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      stale_d      = stale_q;
      timer_d      = timer_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wen_d        = wen_q;
      memop_d      = memop_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      ifu_ready    = 1'b0;
      lsu_ready    = 1'b0;
      // LSU wins only when alone or when the IFU was served last.
      grant_lsu    = bus.i_lsu_req_valid && (!bus.i_ifu_req_valid || (last_grant_q == OWN_IFU));

      // The late beat of a timed-out transaction is swallowed here; it never
      // reaches WAIT because ISSUE holds off until stale has cleared.
      if (stale_q && bus.i_mem_rsp_valid) begin
         stale_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.i_ifu_req_valid || bus.i_lsu_req_valid) begin
               ifu_ready    = !grant_lsu;
               lsu_ready    = grant_lsu;
               owner_d      = grant_lsu;
               last_grant_d = grant_lsu;
               if (grant_lsu) begin
                  addr_d  = bus.i_lsu_addr;
                  wdata_d = bus.i_lsu_wdata;
                  wen_d   = bus.i_lsu_wen;
                  memop_d = bus.i_lsu_memop;
               end else begin
                  addr_d  = bus.i_ifu_addr;
                  wdata_d = '0;
                  wen_d   = 1'b0;
                  memop_d = 3'b010;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!stale_q && bus.i_mem_req_ready) begin
               timer_d = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A real response beats a coincident timeout.
            if (bus.i_mem_rsp_valid) begin
               rdata_d = bus.i_mem_rdata;
               err_d   = bus.i_mem_rsp_err;
               state_d = RESP;
            end else if ((TIMEOUT != 0) && (timer_q == T_LAST)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               stale_d = 1'b1;
               state_d = RESP;
            end else if (timer_q != T_MAX) begin
               timer_d = timer_q + 1'b1;
            end
         end
         RESP: begin
            if (owner_q == OWN_LSU ? bus.i_lsu_rsp_ready : bus.i_ifu_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_ifu_req_ready = ifu_ready;
   assign bus.o_lsu_req_ready = lsu_ready;

   assign bus.o_mem_req_valid = (state_q == ISSUE) && !stale_q;
   assign bus.o_mem_rsp_ready = (state_q == WAIT) || stale_q;
   assign bus.o_mem_addr      = addr_q;
   assign bus.o_mem_wdata     = wdata_q;
   assign bus.o_mem_wen       = wen_q;
   assign bus.o_mem_memop     = memop_q;

   assign bus.o_ifu_rsp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
   assign bus.o_lsu_rsp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
   assign bus.o_ifu_rdata     = (owner_q == OWN_IFU) ? rdata_q : '0;
   assign bus.o_lsu_rdata     = (owner_q == OWN_LSU) ? rdata_q : '0;
   assign bus.o_ifu_rsp_err   = (owner_q == OWN_IFU) && err_q;
   assign bus.o_lsu_rsp_err   = (owner_q == OWN_LSU) && err_q;
endmodule
